// File: rtl/lfa_adc_reader_pkg.sv
// lfa_adc_pkg: shared types, frame constants and the averaging helper for the LFA ADC reader.
package lfa_adc_pkg;
  typedef enum logic [1:0] {SETUP, SHIFT, GAP} state_t;
  typedef enum logic [1:0] {SLOT_L, SLOT_M, SLOT_R} slot_t;
  localparam int FRAME_BITS = 16;
  localparam int SHIFT_CYCLES = 32;
  localparam int RESULT_W = 12;
  function automatic logic [RESULT_W-1:0] avg(input logic [RESULT_W-1:0] a, input logic [RESULT_W-1:0] b);
    logic [RESULT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[RESULT_W:1];
  endfunction
endpackage

// File: rtl/lfa_adc_reader_if.sv
// lfa_adc_reader_if: ADC pins plus the left/middle/right readings handed to the controller.
interface lfa_adc_reader_if;
  import lfa_adc_pkg::*;
  logic adc_cs_n;
  logic adc_sck;
  logic adc_din;
  logic adc_dout;
  logic [RESULT_W-1:0] left;
  logic [RESULT_W-1:0] middle;
  logic [RESULT_W-1:0] right;
  logic sample_valid;
  modport master(output adc_cs_n, adc_sck, adc_din, left, middle, right, sample_valid, input adc_dout);
  modport slave(input adc_cs_n, adc_sck, adc_din, left, middle, right, sample_valid, output adc_dout);
endinterface

// File: rtl/lfa_adc_reader_adc_spi_frame.sv
// adc_spi_frame: one 16-bit ADC128S022 transfer; resets into SETUP, idles in GAP until start_i.
module adc_spi_frame
  import lfa_adc_pkg::*;
(
  input  logic                clk_3125KHz,
  input  logic                rst,
  input  logic                start_i,
  input  logic [2:0]          addr_i,
  input  logic                dout_i,
  output logic                done_o,
  output logic [RESULT_W-1:0] data_o,
  output logic                sck_o,
  output logic                din_o,
  output logic                cs_n_o
);
  state_t state_q, state_d;
  logic [4:0] b_q, b_d;
  logic [2:0] addr_q, addr_d;
  logic [RESULT_W-2:0] sr_q, sr_d;
  logic [FRAME_BITS-1:0] word;
  always_ff @(posedge clk_3125KHz) begin
    if (rst) begin
      state_q <= SETUP;
      b_q <= '0;
      addr_q <= '0;
      sr_q <= '0;
    end else begin
      state_q <= state_d;
      b_q <= b_d;
      addr_q <= addr_d;
      sr_q <= sr_d;
    end
  end
  // pins are gated by rst so a reset abandons the frame on the pins immediately
  always_comb begin
    word = {2'b00, addr_q, 11'b0};
    done_o = state_q == SHIFT && b_q == 5'(SHIFT_CYCLES - 1);
    state_d = state_q == SETUP ? SHIFT : done_o ? GAP : (state_q == GAP && start_i) ? SETUP : state_q;
    b_d = state_q == SHIFT ? b_q + 5'd1 : 5'd0;
    addr_d = state_q == SETUP ? addr_i : addr_q;
    sr_d = (state_q == SHIFT && b_q[0]) ? {sr_q[RESULT_W-3:0], dout_i} : sr_q;
    data_o = {sr_q, dout_i};
    cs_n_o = rst || state_q == GAP;
    sck_o = rst || state_q != SHIFT || b_q[0];
    din_o = !rst && state_q == SHIFT && word[4'd15 - b_q[4:1]];
  end
endmodule

// File: rtl/lfa_adc_reader.sv
// lfa_adc_reader: round-robin L/M/R sampling of the ADC128S022 with a one-frame pipeline.
// Define LFA_ADC_FILTER_EN to average each new sample with the previous output.
module lfa_adc_reader
  import lfa_adc_pkg::*;
#(
  parameter logic [2:0] CH_LEFT = 3'd3,
  parameter logic [2:0] CH_MIDDLE = 3'd2,
  parameter logic [2:0] CH_RIGHT = 3'd1,
  parameter int GAP_CYCLES = 16
) (
  input logic clk_3125KHz,
  input logic rst,
  lfa_adc_reader_if.master bus
);
  localparam int GW = $clog2(GAP_CYCLES) + 1;
  slot_t slot_q, slot_d, prv;
  logic discard_q, discard_d, valid_q, valid_d, done, cs_n, start, commit;
  logic [2:0] addr;
  logic [GW-1:0] gap_q, gap_d;
  logic [RESULT_W-1:0] data, upd, left_q, left_d, middle_q, middle_d, right_q, right_d;
`ifdef LFA_ADC_FILTER_EN
  logic [RESULT_W-1:0] cur;
  logic [2:0] first_q, first_d;
  always_ff @(posedge clk_3125KHz) first_q <= rst ? 3'b111 : first_d;
`endif
  adc_spi_frame u_frame (
    .clk_3125KHz(clk_3125KHz),
    .rst(rst),
    .start_i(start),
    .addr_i(addr),
    .dout_i(bus.adc_dout),
    .done_o(done),
    .data_o(data),
    .sck_o(bus.adc_sck),
    .din_o(bus.adc_din),
    .cs_n_o(cs_n)
  );
  assign bus.adc_cs_n = cs_n;
  assign bus.left = left_q;
  assign bus.middle = middle_q;
  assign bus.right = right_q;
  assign bus.sample_valid = valid_q;
  always_ff @(posedge clk_3125KHz) begin
    if (rst) begin
      slot_q <= SLOT_L;
      discard_q <= 1'b1;
      valid_q <= 1'b0;
      gap_q <= '0;
      left_q <= '0;
      middle_q <= '0;
      right_q <= '0;
    end else begin
      slot_q <= slot_d;
      discard_q <= discard_d;
      valid_q <= valid_d;
      gap_q <= gap_d;
      left_q <= left_d;
      middle_q <= middle_d;
      right_q <= right_d;
    end
  end
  // the data finishing now belongs to the slot addressed in the previous frame
  always_comb begin
    addr = slot_q == SLOT_L ? CH_LEFT : slot_q == SLOT_M ? CH_MIDDLE : CH_RIGHT;
    prv = slot_q == SLOT_L ? SLOT_R : slot_q == SLOT_M ? SLOT_L : SLOT_M;
    slot_d = !done ? slot_q : slot_q == SLOT_L ? SLOT_M : slot_q == SLOT_M ? SLOT_R : SLOT_L;
    commit = done && !discard_q;
    discard_d = discard_q && !done;
`ifdef LFA_ADC_FILTER_EN
    cur = prv == SLOT_L ? left_q : prv == SLOT_M ? middle_q : right_q;
    upd = first_q[prv] ? data : avg(cur, data);
    first_d = commit ? first_q & ~(3'b001 << prv) : first_q;
`else
    upd = data;
`endif
    left_d = (commit && prv == SLOT_L) ? upd : left_q;
    middle_d = (commit && prv == SLOT_M) ? upd : middle_q;
    right_d = (commit && prv == SLOT_R) ? upd : right_q;
    valid_d = commit && prv == SLOT_R;
    gap_d = cs_n ? gap_q + 1'b1 : '0;
    start = cs_n && gap_q == GW'(GAP_CYCLES - 1);
  end
endmodule

// File: tb/tb_lfa_adc_reader.sv
// tb_lfa_adc_reader: directed checks of lfa_adc_reader against a behavioural ADC128S022 model.
module tb_lfa_adc_reader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  int errors = 0;
  int checks = 0;
  lfa_adc_reader_if ifc ();
  lfa_adc_reader_if ifc2 ();
  lfa_adc_reader dut (.clk_3125KHz(clk), .rst(rst), .bus(ifc.master));
  lfa_adc_reader #(.GAP_CYCLES(1)) dut2 (.clk_3125KHz(clk), .rst(rst), .bus(ifc2.master));
  assign ifc2.adc_dout = 1'b0;
  always #160 clk = ~clk;
  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;
`ifdef LFA_ADC_FILTER_EN
  localparam logic [11:0] STEP2 = 12'h7FF, STEP3 = 12'hBFF;
`else
  localparam logic [11:0] STEP2 = 12'hFFF, STEP3 = 12'hFFF;
`endif
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  // ADC model: each frame returns the channel addressed in the previous frame
  logic force_en = 1'b0;
  logic [11:0] force_val = 12'h000;
  logic [15:0] resp = 16'h0, w = 16'h0;
  logic [2:0] prev_addr = 3'd0;
  int fidx = 0, rcnt = 0, alen = 0;
  logic [2:0] addr_log [64];
  function automatic logic [11:0] model(input logic [2:0] a);
    return force_en ? force_val : a == 3'd3 ? 12'hABC : a == 3'd2 ? 12'h123 : a == 3'd1 ? 12'hFFF : 12'h000;
  endfunction
  always @(negedge ifc.adc_cs_n) begin
    fidx = 0;
    rcnt = 0;
    w = 16'h0;
    resp = {4'h0, model(prev_addr)};
  end
  always @(posedge ifc.adc_cs_n) begin
    if (rcnt == 16 && alen < 64) begin
      addr_log[alen] = w[13:11];
      alen++;
    end
    if (rcnt >= 5) prev_addr = w[13:11];
  end
  always @(negedge ifc.adc_sck) if (!ifc.adc_cs_n && fidx < 16) begin
    ifc.adc_dout = resp[15-fidx];
    fidx++;
  end
  always @(posedge ifc.adc_sck) if (!rst && !ifc.adc_cs_n && rcnt < 16) begin
    w[15-rcnt] = ifc.adc_din;
    rcnt++;
  end
  // pin-level monitors: din edges vs sck, cs_n low length, GAP=1 instance pulse times
  int din_viol = 0, cs_viol = 0, frames = 0, lowcnt = 0, n2 = 0;
  int t2 [2];
  logic pdin = 1'b0, psck = 1'b1, prst = 1'b1;
  always @(negedge clk) begin
    if (!rst && !prst && ifc.adc_din != pdin && !(psck && !ifc.adc_sck)) din_viol++;
    if (rst) lowcnt = 0;
    else if (!ifc.adc_cs_n) lowcnt++;
    else if (lowcnt > 0) begin
      if (lowcnt != 33) cs_viol++;
      frames++;
      lowcnt = 0;
    end
    if (ifc2.sample_valid && n2 < 2) begin
      t2[n2] = cyc;
      n2++;
    end
    pdin = ifc.adc_din;
    psck = ifc.adc_sck;
    prst = rst;
  end
  task automatic do_reset(input int n);
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (n) @(posedge clk);
    #1 rst = 1'b0;
  endtask
  task automatic wait_valid(output int c);
    c = -1;
    for (int i = 0; i < 400 && c < 0; i++) begin
      @(negedge clk);
      if (ifc.sample_valid) c = cyc;
    end
  endtask
  task automatic wait_cyc(input int n);
    for (int i = 0; i < 400 && cyc < n; i++) @(negedge clk);
    check("reach_cycle", 32'(cyc), 32'(n));
  endtask
  initial begin
    int c;
    repeat (3) @(negedge clk);
    check("rst_cs_n", 32'(ifc.adc_cs_n), 32'h1);
    check("rst_sck", 32'(ifc.adc_sck), 32'h1);
    check("rst_din", 32'(ifc.adc_din), 32'h0);
    check("rst_left", 32'(ifc.left), 32'h0);
    check("rst_mid_right", 32'({ifc.middle, ifc.right}), 32'h0);
    check("rst_valid", 32'(ifc.sample_valid), 32'h0);
    do_reset(1);
    @(negedge clk);
    check("setup_cs_n", 32'(ifc.adc_cs_n), 32'h0);
    wait_cyc(50);
    check("discard_left", 32'(ifc.left), 32'h0);
    wait_valid(c);
    check("first_valid_cyc", 32'(c), 32'd180);
    check("left", 32'(ifc.left), 32'hABC);
    check("middle", 32'(ifc.middle), 32'h123);
    check("right", 32'(ifc.right), 32'hFFF);
    @(negedge clk);
    check("valid_width", 32'(ifc.sample_valid), 32'h0);
    repeat (60) @(negedge clk);
    check("left_hold", 32'(ifc.left), 32'hABC);
    wait_valid(c);
    check("period", 32'(c), 32'd327);
    check("left_steady", 32'(ifc.left), 32'hABC);
    check("addr_count", 32'(alen >= 6), 32'h1);
    for (int i = 0; i < 6; i++) check($sformatf("addr%0d", i), 32'(addr_log[i]), 32'(3 - (i % 3)));
    check("gap1_first", 32'(t2[0]), 32'd135);
    check("gap1_period", 32'(t2[1] - t2[0]), 32'd102);
    do_reset(2);
    wait_cyc(109);
    check("pre_left", 32'(ifc.left), 32'hABC);
    check("pre_middle", 32'(ifc.middle), 32'h0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_cs_n", 32'(ifc.adc_cs_n), 32'h1);
    check("mid_sck", 32'(ifc.adc_sck), 32'h1);
    check("mid_left", 32'(ifc.left), 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    wait_valid(c);
    check("rel_valid_cyc", 32'(c), 32'd180);
    check("rel_left", 32'(ifc.left), 32'hABC);
    check("rel_middle", 32'(ifc.middle), 32'h123);
    check("rel_right", 32'(ifc.right), 32'hFFF);
    force_en = 1'b1;
    force_val = 12'h000;
    do_reset(2);
    wait_valid(c);
    check("step0_cyc", 32'(c), 32'd180);
    check("step0", 32'({ifc.left, ifc.middle, ifc.right}), 32'h0);
    force_val = 12'hFFF;
    wait_valid(c);
    check("step1_cyc", 32'(c), 32'd327);
    check("step1_left", 32'(ifc.left), 32'(STEP2));
    check("step1_right", 32'(ifc.right), 32'(STEP2));
    wait_valid(c);
    check("step2_left", 32'(ifc.left), 32'(STEP3));
    check("step2_middle", 32'(ifc.middle), 32'(STEP3));
    check("din_edges", 32'(din_viol), 32'h0);
    check("cs_low_len", 32'(cs_viol), 32'h0);
    check("frames_seen", 32'(frames > 20), 32'h1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
